// File: rtl/util_fifo_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// util_fifo_arbiter_pkg
// Shared constants and state encoding for the util FIFO family arbiter.
//   BITLEN    : data width per requester and of the FIFO write port
//   NUM_REQ   : requesters sharing one FIFO write port
//   REQ_BIT   : requester index width
//   BURST_LEN : max beats per grant before re-arbitration
//   BURST_BIT : burst counter width (holds 0..BURST_LEN)
// ---------------------------------------------------------------------------
package util_fifo_arbiter_pkg;
  localparam int BITLEN    = 64;
  localparam int NUM_REQ   = 4;
  localparam int REQ_BIT   = 2;
  localparam int BURST_LEN = 4;
  localparam int BURST_BIT = 3;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    GRANT = 1'b1
  } arb_state_e;
endpackage

// File: rtl/util_fifo_arbiter_if.sv
// ---------------------------------------------------------------------------
// util_fifo_arbiter_if
// Requester-side and FIFO-side bundle of the arbiter.
//   req_valid/req_data/req_ready : per-requester valid/ready handshake
//   fifo_full/fifo_wr_en/fifo_din: shared FIFO write port
//   grant_id/busy                : current grant status
// master = environment (requesters + FIFO), slave = arbiter.
// ---------------------------------------------------------------------------
interface util_fifo_arbiter_if #(
  parameter int BW = util_fifo_arbiter_pkg::BITLEN,
  parameter int NR = util_fifo_arbiter_pkg::NUM_REQ,
  parameter int RB = util_fifo_arbiter_pkg::REQ_BIT
);
  logic [NR-1:0]         req_valid;
  logic [NR-1:0][BW-1:0] req_data;   // requester i at bits [i*BW +: BW]
  logic [NR-1:0]         req_ready;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [BW-1:0]         fifo_din;
  logic [RB-1:0]         grant_id;
  logic                  busy;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );
endinterface

// File: rtl/util_fifo_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// util_rr_pick
// Combinational round-robin search: first set bit of req_i starting at
// (last_i+1) mod NR, wrapping upward.
//   req_i  : request vector
//   last_i : index of the previous winner
//   win_o  : winning index (0 when any_o is low)
//   any_o  : at least one request present
// ---------------------------------------------------------------------------
module util_rr_pick #(
  parameter int NR = 4,
  parameter int RB = 2
) (
  input  logic [NR-1:0] req_i,
  input  logic [RB-1:0] last_i,
  output logic [RB-1:0] win_o,
  output logic          any_o
);
  logic [RB-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest set
  // request (highest priority) is the last one written.
  always_comb begin
    win_o = '0;
    cand  = '0;
    any_o = |req_i;
    for (int k = NR; k >= 1; k--) begin
      cand = RB'((int'(last_i) + k) % NR);
      if (req_i[cand]) win_o = cand;
    end
  end
endmodule

// File: rtl/util_fifo_arbiter.sv
// ---------------------------------------------------------------------------
// util_fifo_arbiter
// Round-robin arbiter funnelling NUM_REQ requesters into one FIFO write
// port, in bursts of up to BURST_LEN beats per grant.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : util_fifo_arbiter_if.slave (handshakes, FIFO port, status)
// ---------------------------------------------------------------------------
module util_fifo_arbiter
  import util_fifo_arbiter_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  util_fifo_arbiter_if.slave bus
);
  arb_state_e           state_q, state_d;
  logic [BURST_BIT-1:0] cnt_q,   cnt_d;
  logic [REQ_BIT-1:0]   last_q,  last_d;
  logic [REQ_BIT-1:0]   grant_q, grant_d;

  logic [REQ_BIT-1:0]   win;
  logic                 any;
  logic                 cur_valid;
  logic                 beat;

  util_rr_pick #(.NR(NUM_REQ), .RB(REQ_BIT)) u_pick (
    .req_i  (bus.req_valid),
    .last_i (last_q),
    .win_o  (win),
    .any_o  (any)
  );

  assign cur_valid = bus.req_valid[grant_q];
  // rst_n gates the beat so a burst cut by reset writes nothing that cycle.
  assign beat      = rst_n && (state_q == GRANT) && cur_valid && !bus.fifo_full;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    unique case (state_q)
      ARB: begin
        if (any) begin
          grant_d = win;
          last_d  = win;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!cur_valid) begin
          state_d = ARB;
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BURST_BIT'(BURST_LEN - 1)) state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB;
      cnt_q   <= '0;
      last_q  <= REQ_BIT'(NUM_REQ - 1);  // index 0 wins the first search
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  // Outputs are forced low while rst_n is low, even before the state clears.
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      bus.req_ready[i] = beat && (grant_q == REQ_BIT'(i));
  end

  assign bus.busy       = rst_n && (state_q == GRANT);
  assign bus.fifo_wr_en = beat;
  assign bus.fifo_din   = bus.busy ? bus.req_data[grant_q] : '0;
  assign bus.grant_id   = grant_q;
endmodule

// File: tb/tb_util_fifo_arbiter.sv
module tb_util_fifo_arbiter;
  import util_fifo_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  util_fifo_arbiter_if bus ();

  util_fifo_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: who holds the FIFO (-1 = nobody), beats done, previous winner.
  int m_hold, m_beats, m_last;

  // Observations from the DUT
  logic [REQ_BIT-1:0] gq[$];   // grant_id at each start of a grant
  logic [BITLEN-1:0]  wq[$];   // fifo_din of each write
  logic               prev_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic cycle();
    logic [NUM_REQ-1:0] e_rdy;
    logic               e_wr, e_busy;
    logic [BITLEN-1:0]  e_din;
    @(negedge clk);
    e_rdy = '0; e_wr = 1'b0; e_busy = 1'b0; e_din = '0;
    if (rst_n && m_hold >= 0) begin
      e_busy        = 1'b1;
      e_wr          = bus.req_valid[m_hold] & ~bus.fifo_full;
      e_rdy[m_hold] = e_wr;
      e_din         = bus.req_data[m_hold];
    end
    chk("busy", 64'(bus.busy), 64'(e_busy));
    chk("fifo_wr_en", 64'(bus.fifo_wr_en), 64'(e_wr));
    chk("req_ready", 64'(bus.req_ready), 64'(e_rdy));
    if (e_busy) chk("grant_id", 64'(bus.grant_id), 64'(m_hold));
    if (e_busy || !rst_n) chk("fifo_din", bus.fifo_din, e_din);
    if (bus.busy && !prev_busy) gq.push_back(bus.grant_id);
    if (bus.fifo_wr_en) wq.push_back(bus.fifo_din);
    prev_busy = bus.busy;
    @(posedge clk);
    if (!rst_n) begin
      m_hold = -1; m_beats = 0; m_last = NUM_REQ - 1;
    end else if (m_hold < 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (m_hold < 0 && bus.req_valid[(m_last + k) % NUM_REQ]) begin
          m_hold = (m_last + k) % NUM_REQ;
          m_last = m_hold;
          m_beats = 0;
        end
      end
    end else if (!bus.req_valid[m_hold]) begin
      m_hold = -1;
    end else if (!bus.fifo_full) begin
      m_beats++;
      if (m_beats == BURST_LEN) m_hold = -1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    chk("grant_id_after_reset", 64'(bus.grant_id), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    m_hold = -1; m_beats = 0; m_last = NUM_REQ - 1;
    prev_busy = 1'b0;

    // Two alternating requesters, FIFO never full
    do_reset();
    gq.delete();
    bus.req_valid = 4'b0101;
    for (int c = 0; c < 12; c++) begin
      for (int r = 0; r < NUM_REQ; r++) bus.req_data[r] = {$urandom, $urandom};
      cycle();
    end
    chk("alt_n_grants", 64'(gq.size()), 64'd3);
    if (gq.size() >= 3) begin
      chk("alt_g0", 64'(gq[0]), 64'd0);
      chk("alt_g1", 64'(gq[1]), 64'd2);
      chk("alt_g2", 64'(gq[2]), 64'd0);
    end

    // Requester 1 gives 2 beats and drops; requester 3 then wins at once
    bus.req_valid = '0;
    cycle(); cycle();
    wq.delete(); gq.delete();
    bus.req_valid = 4'b0010;
    bus.req_data[1] = 64'h11;
    cycle(); cycle(); cycle();
    bus.req_valid = '0;
    cycle();
    chk("r1_writes", 64'(wq.size()), 64'd2);
    bus.req_valid = 4'b1000;
    cycle(); cycle();
    chk("r3_immediate", 64'(gq.size()), 64'd2);
    if (gq.size() >= 2) chk("r3_grant", 64'(gq[1]), 64'd3);

    // Requester 3 with a 3-cycle full stall after beat 2
    do_reset();
    wq.delete();
    bus.req_valid = 4'b1000;
    bus.req_data[3] = 64'hD0;
    cycle();
    cycle();
    bus.req_data[3] = 64'hD1;
    cycle();
    bus.fifo_full = 1'b1;
    bus.req_data[3] = 64'hD2;
    cycle(); cycle(); cycle();
    bus.fifo_full = 1'b0;
    cycle();
    bus.req_data[3] = 64'hD3;
    cycle();
    bus.req_valid = '0;
    cycle();
    chk("stall_writes", 64'(wq.size()), 64'd4);
    if (wq.size() >= 4) begin
      chk("stall_w0", wq[0], 64'hD0);
      chk("stall_w1", wq[1], 64'hD1);
      chk("stall_w2", wq[2], 64'hD2);
      chk("stall_w3", wq[3], 64'hD3);
    end

    // All four valid, distinct data
    do_reset();
    gq.delete();
    for (int r = 0; r < NUM_REQ; r++) bus.req_data[r] = 64'(8'hA0 + r);
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 25; c++) cycle();
    chk("all_n_grants", 64'(gq.size()), 64'd5);
    if (gq.size() >= 5)
      for (int i = 0; i < 5; i++) chk("all_order", 64'(gq[i]), 64'(i % NUM_REQ));

    // Reset during beat 2 of a burst
    do_reset();
    bus.req_valid = 4'b0100;
    cycle(); cycle();
    wq.delete();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("rst_mid_no_write", 64'(wq.size()), 64'd0);
    gq.delete();
    bus.req_valid = 4'b1111;
    cycle(); cycle();
    chk("rst_mid_grants", 64'(gq.size()), 64'd1);
    if (gq.size() >= 1) chk("rst_mid_next", 64'(gq[0]), 64'd0);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      bus.req_valid = NUM_REQ'($urandom);
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      for (int r = 0; r < NUM_REQ; r++) bus.req_data[r] = {$urandom, $urandom};
      rst_n = ($urandom_range(0, 49) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/util_fifo_arbiter.md
UTIL_FIFO_ARBITER -- requirements
Module: util_fifo_arbiter

Interface
REQ-001 Parameter BITLEN, 64, data width of each requester and of the FIFO write port.
REQ-002 Parameter NUM_REQ, 4, number of requesters sharing one FIFO write port.
REQ-003 Parameter REQ_BIT, 2, width of a requester index (log2 NUM_REQ).
REQ-004 Parameter BURST_LEN, 4, maximum beats per grant before re-arbitration.
REQ-005 Parameter BURST_BIT, 3, burst counter width (holds 0..BURST_LEN).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 req_valid  input  NUM_REQ  per-requester data-valid.
REQ-009 req_data  input  NUM_REQ*BITLEN  packed requester data; requester i occupies bits [i*BITLEN +: BITLEN].
REQ-010 req_ready  output  NUM_REQ  per-requester accept strobe; beat transfers when valid and ready are both high.
REQ-011 fifo_full  input  1  full flag from the shared FIFO.
REQ-012 fifo_wr_en  output  1  FIFO write enable.
REQ-013 fifo_din  output  BITLEN  FIFO write data.
REQ-014 grant_id  output  REQ_BIT  index of the current grant holder; valid while busy is high.
REQ-015 busy  output  1  high while in GRANT state.

Function
REQ-016 FSM SHALL have two states: ARB and GRANT.
REQ-017 ARB: if any req_valid bit is high, the block SHALL pick a winner round-robin, searching from index (last_grant+1) mod NUM_REQ upward with wrap, and SHALL register it into grant_id; next state GRANT; otherwise SHALL stay in ARB.
REQ-018 ARB SHALL assert no req_ready and no fifo_wr_en; arbitration costs exactly one cycle.
REQ-019 GRANT: fifo_wr_en = req_valid[grant_id] & ~fifo_full; req_ready[grant_id] SHALL equal fifo_wr_en; all other req_ready bits SHALL be 0 (combinational from registered state).
REQ-020 fifo_din SHALL equal req_data slice grant_id whenever in GRANT; its value is don't-care in ARB.
REQ-021 Each transferred beat SHALL increment the burst counter; the counter SHALL be cleared on entering GRANT.
REQ-022 GRANT SHALL return to ARB after the beat that brings the counter to BURST_LEN, or in any cycle where req_valid[grant_id] is low, whichever occurs first.
REQ-023 fifo_full high in GRANT SHALL stall without a transfer, without a counter change and without losing the grant.
REQ-024 last_grant SHALL update to grant_id on every ARB->GRANT transition.
REQ-025 Requests arriving at other indices during GRANT SHALL wait; no preemption.
REQ-026 With a single continuously valid requester, the pattern SHALL repeat BURST_LEN beats then one ARB cycle.

Reset
REQ-027 rst_n low at a rising edge SHALL force: state ARB, burst counter 0, last_grant NUM_REQ-1 (so index 0 wins first), grant_id 0.
REQ-028 During and immediately after reset, req_ready, fifo_wr_en and busy SHALL be 0; fifo_din SHALL be 0.
REQ-029 Reset asserted mid-burst SHALL abandon the burst; no partial-beat write SHALL occur in the reset cycle.

Structure
REQ-030 Constants BITLEN, NUM_REQ, REQ_BIT, BURST_LEN and BURST_BIT and the ARB/GRANT state encodings SHALL be defined in the shared util package used by the util_FIFO family.
REQ-031 The round-robin next-winner search SHALL be a separate combinational sub-module, util_rr_pick (inputs request vector and last index; outputs winner index and any-valid).

Verification
REQ-032 Reset, then req_valid=4'b0101 held, FIFO never full -> grant 0 for 4 beats, 1 ARB cycle, grant 2 for 4 beats, 1 ARB cycle, grant 0.
REQ-033 Requester 1 only, asserting valid for 2 beats then dropping -> 2 writes, return to ARB, busy low; next request from 3 wins immediately.
REQ-034 Requester 3 in GRANT, fifo_full high for 3 cycles after beat 2 -> fifo_wr_en 0 for those 3 cycles, then beats 3 and 4, 4 writes total, data order preserved.
REQ-035 All 4 requesters valid with distinct data 0xA0..0xA3 -> FIFO receives bursts in order 0,1,2,3,0 and fifo_din matches the holder's data every beat.
REQ-036 rst_n low for 1 cycle during beat 2 of a burst -> no write that cycle, outputs 0, the next grant goes to index 0.
